// File: rtl/rv32i_types.sv
// rv32i_types: shared BTB update entry and write-controller state types
package rv32i_types;
  localparam int BTB_S_INDEX = 4;
  localparam int BTB_TAG_WIDTH = 32 - 2 - BTB_S_INDEX;
  typedef struct packed {
    logic [BTB_S_INDEX-1:0]   idx;
    logic [BTB_TAG_WIDTH-1:0] tag;
    logic [31:0]              target;
    logic                     valid;
  } btb_upd_t;
  typedef enum logic {IDLE_DRAIN, FLUSH} btb_upd_state_t;
endpackage

// File: rtl/btb_upd_fifo.sv
// btb_upd_fifo: sync FIFO of btb_upd_t (clk, rst, push/pop/clear in; din; dout=head, full, empty out)
module btb_upd_fifo
  import rv32i_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  logic     clear,
  input  btb_upd_t din,
  output btb_upd_t dout,
  output logic     full,
  output logic     empty
);
  localparam int AW = $clog2(DEPTH);
  btb_upd_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full && !clear;
  assign do_pop = pop && !empty && !clear;
  assign dout = mem[rp];
  always_ff @(posedge clk) if (do_push) mem[wp] <= din;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (clear) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/btb_update_ctrl.sv
// btb_update_ctrl: BTB port-0 writer (upd_* handshake in, flush_req/flush_busy sweep, arr_* write port out)
module btb_update_ctrl
  import rv32i_types::*;
#(
  parameter int S_INDEX    = 4,
  parameter int TAG_WIDTH  = 26,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 upd_valid,
  output logic                 upd_ready,
  input  logic [31:0]          upd_pc,
  input  logic [31:0]          upd_target,
  input  logic                 upd_taken,
  input  logic                 upd_btb_hit,
  input  logic                 flush_req,
  output logic                 flush_busy,
  output logic                 arr_csb,
  output logic                 arr_web,
  output logic [S_INDEX-1:0]   arr_addr,
  output logic                 valid_din,
  output logic [TAG_WIDTH-1:0] tag_din,
  output logic [31:0]          target_din
);
  btb_upd_state_t state;
  logic [S_INDEX-1:0] sweep_cnt;
  btb_upd_t din, head;
  logic full, empty, idle, push, pop, clear, drain, pc_unused;
  assign pc_unused = ^upd_pc[1:0];
  assign idle = state == IDLE_DRAIN;
  assign upd_ready = idle && !full;
  assign push = upd_valid && upd_ready && (upd_taken || upd_btb_hit) && !flush_req;
  assign pop = idle && !empty && !flush_req;
  assign clear = idle && flush_req;
  assign din.idx = upd_pc[S_INDEX+1:2];
  assign din.tag = upd_taken ? upd_pc[31:S_INDEX+2] : '0;
  assign din.target = upd_taken ? upd_target : '0;
  assign din.valid = upd_taken;
  btb_upd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .clear(clear),
    .din(din), .dout(head), .full(full), .empty(empty)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE_DRAIN;
      sweep_cnt <= '0;
    end else if (idle) begin
      if (flush_req) begin
        state <= FLUSH;
        sweep_cnt <= '0;
      end
    end else begin
      sweep_cnt <= sweep_cnt + 1'b1;
      if (&sweep_cnt) state <= IDLE_DRAIN;
    end
  end
  assign flush_busy = !idle;
  assign drain = idle && !empty;
  always_comb begin
    arr_csb = !(flush_busy || drain);
    arr_web = !(flush_busy || drain);
    arr_addr = flush_busy ? sweep_cnt : drain ? head.idx : '0;
    valid_din = drain && head.valid;
    tag_din = drain ? head.tag : '0;
    target_din = drain ? head.target : '0;
  end
endmodule

// File: tb/tb_btb_update_ctrl.sv
// tb_btb_update_ctrl: directed bench with queue-level reference model and port-1 array model
module tb_btb_update_ctrl;
  logic clk = 0, rst = 1;
  logic upd_valid = 0, upd_taken = 0, upd_btb_hit = 0, flush_req = 0;
  logic [31:0] upd_pc = 0, upd_target = 0;
  logic upd_ready, flush_busy, arr_csb, arr_web, valid_din;
  logic [3:0] arr_addr;
  logic [25:0] tag_din;
  logic [31:0] target_din;
  int checks = 0, errors = 0;
  btb_update_ctrl #(.S_INDEX(4), .TAG_WIDTH(26), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
    .upd_btb_hit(upd_btb_hit), .flush_req(flush_req), .flush_busy(flush_busy),
    .arr_csb(arr_csb), .arr_web(arr_web), .arr_addr(arr_addr),
    .valid_din(valid_din), .tag_din(tag_din), .target_din(target_din)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", n, a, e);
    end
  endtask
  typedef struct {
    logic [3:0] idx;
    logic [25:0] tag;
    logic [31:0] tgt;
    logic v;
  } ent_t;
  ent_t q[$];
  bit m_busy;
  int m_sweep;
  always @(posedge clk or posedge rst) begin
    bit rdy;
    ent_t e;
    if (rst) begin
      q.delete();
      m_busy = 0;
      m_sweep = 0;
    end else if (m_busy) begin
      m_sweep++;
      if (m_sweep == 16) begin
        m_busy = 0;
        m_sweep = 0;
      end
    end else begin
      rdy = q.size() < 4;
      if (flush_req) begin
        q.delete();
        m_busy = 1;
        m_sweep = 0;
      end else begin
        if (q.size() > 0) void'(q.pop_front());
        if (upd_valid && rdy && (upd_taken || upd_btb_hit)) begin
          e.idx = upd_pc[5:2];
          e.tag = upd_taken ? upd_pc[31:6] : 26'd0;
          e.tgt = upd_taken ? upd_target : 32'd0;
          e.v = upd_taken;
          q.push_back(e);
        end
      end
    end
  end
  bit mem_v [16];
  bit pend, pval;
  logic [3:0] paddr;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend = 0;
      foreach (mem_v[i]) mem_v[i] = 0;
    end else begin
      if (pend) mem_v[paddr] = pval;
      pend = !arr_csb && !arr_web;
      paddr = arr_addr;
      pval = valid_din;
    end
  end
  always @(posedge clk) begin
    logic wr;
    logic [3:0] ea;
    logic ev;
    logic [25:0] et;
    logic [31:0] eg;
    #1;
    wr = m_busy || q.size() > 0;
    ea = m_busy ? 4'(m_sweep) : q.size() > 0 ? q[0].idx : 4'd0;
    ev = !m_busy && q.size() > 0 && q[0].v;
    et = !m_busy && q.size() > 0 ? q[0].tag : 26'd0;
    eg = !m_busy && q.size() > 0 ? q[0].tgt : 32'd0;
    chk("upd_ready", upd_ready, !m_busy && q.size() < 4);
    chk("flush_busy", flush_busy, m_busy);
    chk("arr_csb", arr_csb, !wr);
    chk("arr_web", arr_web, !wr);
    chk("arr_addr", arr_addr, ea);
    chk("valid_din", valid_din, ev);
    chk("tag_din", tag_din, et);
    chk("target_din", target_din, eg);
  end
  task automatic send(logic [31:0] pc, logic [31:0] tgt, logic tk, logic hit);
    upd_valid = 1;
    upd_pc = pc;
    upd_target = tgt;
    upd_taken = tk;
    upd_btb_hit = hit;
    @(negedge clk);
    upd_valid = 0;
  endtask
  initial begin
    int n, s;
    repeat (2) @(negedge clk);
    chk("rst_ready", upd_ready, 1);
    chk("rst_csb", arr_csb, 1);
    chk("rst_busy", flush_busy, 0);
    rst = 0;
    @(negedge clk);
    send(32'h0000_1234, 32'h0000_2000, 1, 0);
    chk("t1_csb", arr_csb, 0);
    chk("t1_web", arr_web, 0);
    chk("t1_addr", arr_addr, 4'hD);
    chk("t1_tag", tag_din, 26'h48);
    chk("t1_target", target_din, 32'h2000);
    chk("t1_valid", valid_din, 1);
    @(negedge clk);
    chk("t1_not_yet", mem_v[13], 0);
    @(negedge clk);
    chk("t1_read", mem_v[13], 1);
    for (int i = 0; i < 5; i++) begin
      upd_valid = 1;
      upd_pc = 32'h100 + 32'(i * 4);
      upd_target = 32'h3000 + 32'(i);
      upd_taken = 1;
      upd_btb_hit = 0;
      @(negedge clk);
      chk("t2_ready", upd_ready, 1);
      chk("t2_order", arr_addr, 4'(i));
    end
    upd_valid = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) chk("t2_read", mem_v[i], 1);
    send(32'h40, 32'h5555, 0, 1);
    chk("t3_inv_addr", arr_addr, 0);
    chk("t3_inv_valid", valid_din, 0);
    chk("t3_inv_csb", arr_csb, 0);
    send(32'h44, 32'h6666, 0, 0);
    chk("t3_drop_csb", arr_csb, 1);
    @(negedge clk);
    chk("t3_inv_read", mem_v[0], 0);
    chk("t3_drop_read", mem_v[1], 1);
    send(32'h88, 32'h0, 0, 1);
    send(32'h88, 32'h7777, 1, 0);
    repeat (3) @(negedge clk);
    chk("t3_order_read", mem_v[2], 1);
    flush_req = 1;
    upd_valid = 1;
    upd_pc = 32'h3C;
    upd_target = 32'h9999;
    upd_taken = 1;
    @(negedge clk);
    flush_req = 0;
    n = 0;
    for (int k = 0; k < 40 && flush_busy; k++) begin
      n++;
      chk("t4_ready_low", upd_ready, 0);
      flush_req = n == 5;
      @(negedge clk);
    end
    flush_req = 0;
    upd_valid = 0;
    chk("t4_busy_cycles", n, 16);
    chk("t5_dropped", arr_csb, 1);
    repeat (3) @(negedge clk);
    s = 0;
    foreach (mem_v[i]) s += int'(mem_v[i]);
    chk("t4_all_invalid", s, 0);
    flush_req = 1;
    @(negedge clk);
    flush_req = 0;
    n = 0;
    while (n < 20 && !(flush_busy && arr_addr == 4'd7)) begin
      n++;
      @(negedge clk);
    end
    chk("t6_reach_7", n < 20, 1);
    rst = 1;
    #1;
    chk("t6_ready", upd_ready, 1);
    chk("t6_busy", flush_busy, 0);
    chk("t6_csb", arr_csb, 1);
    chk("t6_web", arr_web, 1);
    chk("t6_addr", arr_addr, 0);
    @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);
    chk("t6_idle_csb", arr_csb, 1);
    chk("t6_idle_busy", flush_busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
